// File: rtl/e5m2_mac_seq.sv
// Job sequencer for one E5M2 MAC: streams N operand pairs with first/last markers,
// tracks MAC latency and holds the FP16 result of the job for a valid/ready consumer.
module e5m2_mac_seq #(
    parameter int LEN_W   = 8,
    parameter int MAC_LAT = 2
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_valid_i,
    output logic             start_ready_o,
    input  logic [LEN_W-1:0] len_i,
    input  logic             op_valid_i,
    output logic             op_ready_o,
    input  logic [7:0]       a_i,
    input  logic [7:0]       b_i,
    output logic             mac_valid_o,
    output logic             mac_clr_o,
    output logic             mac_last_o,
    output logic [7:0]       mac_a_o,
    output logic [7:0]       mac_b_o,
    input  logic [15:0]      mac_res_i,
    output logic             res_valid_o,
    input  logic             res_ready_i,
    output logic [15:0]      res_o,
    output logic             res_nan_o,
    output logic             res_inf_o,
    output logic             busy_o
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

    state_t             r_state;
    state_t             w_state_next;
    logic [LEN_W-1:0]   r_cnt;
    logic               r_first;
    logic               r_nan;
    logic               r_inf;
    logic               r_mac_valid;
    logic               r_mac_clr;
    logic               r_mac_last;
    logic [7:0]         r_mac_a;
    logic [7:0]         r_mac_b;
    logic [MAC_LAT-1:0] r_last_pipe;
    logic [15:0]        r_res;

    logic w_start_hs;
    logic w_op_hs;
    logic w_op_last;
    logic w_last_out;
    logic w_op_nan;
    logic w_op_inf;

    function automatic logic f_is_nan(input logic [7:0] x);
        return (&x[6:2]) & (|x[1:0]);
    endfunction

    function automatic logic f_is_inf(input logic [7:0] x);
        return (&x[6:2]) & ~(|x[1:0]);
    endfunction

    assign w_start_hs = start_valid_i & (r_state == S_IDLE);
    assign w_op_hs    = op_valid_i & (r_state == S_RUN);
    assign w_op_last  = (r_cnt == LEN_W'(1));
    assign w_last_out = r_last_pipe[MAC_LAT-1];
    assign w_op_nan   = f_is_nan(a_i) | f_is_nan(b_i);
    assign w_op_inf   = f_is_inf(a_i) | f_is_inf(b_i);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next  = r_state;
        start_ready_o = 1'b0;
        op_ready_o    = 1'b0;
        res_valid_o   = 1'b0;
        busy_o        = 1'b1;
        case (r_state)
            S_IDLE: begin
                start_ready_o = 1'b1;
                busy_o        = 1'b0;
                if (start_valid_i) begin
                    w_state_next = (len_i == '0) ? S_DONE : S_RUN;
                end
            end
            S_RUN: begin
                op_ready_o = 1'b1;
                if (op_valid_i && w_op_last) begin
                    w_state_next = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (w_last_out) begin
                    w_state_next = S_DONE;
                end
            end
            S_DONE: begin
                res_valid_o = 1'b1;
                if (res_ready_i) begin
                    w_state_next = S_IDLE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_cnt       <= '0;
            r_first     <= 1'b0;
            r_nan       <= 1'b0;
            r_inf       <= 1'b0;
            r_mac_valid <= 1'b0;
            r_mac_clr   <= 1'b0;
            r_mac_last  <= 1'b0;
            r_mac_a     <= '0;
            r_mac_b     <= '0;
            r_last_pipe <= '0;
            r_res       <= '0;
        end else begin
            r_mac_valid <= w_op_hs;
            r_mac_clr   <= w_op_hs & r_first;
            r_mac_last  <= w_op_hs & w_op_last;
            if (w_op_hs) begin
                r_mac_a <= a_i;
                r_mac_b <= b_i;
                r_cnt   <= r_cnt - LEN_W'(1);
                r_first <= 1'b0;
                r_nan   <= r_nan | w_op_nan;
                r_inf   <= r_inf | w_op_inf;
            end
            if (w_start_hs) begin
                r_cnt   <= len_i;
                r_first <= 1'b1;
                r_nan   <= 1'b0;
                r_inf   <= 1'b0;
                if (len_i == '0) begin
                    r_res <= '0;
                end
            end
            // Only the last issue of a job travels down the pipe, so intermediate sums are never captured
            r_last_pipe[0] <= r_mac_valid & r_mac_last;
            for (int i = 1; i < MAC_LAT; i++) begin
                r_last_pipe[i] <= r_last_pipe[i-1];
            end
            if (w_last_out && (r_state == S_DRAIN)) begin
                r_res <= mac_res_i;
            end
        end
    end

    assign mac_valid_o = r_mac_valid;
    assign mac_clr_o   = r_mac_clr;
    assign mac_last_o  = r_mac_last;
    assign mac_a_o     = r_mac_a;
    assign mac_b_o     = r_mac_b;
    assign res_o       = r_res;
    assign res_nan_o   = r_nan;
    assign res_inf_o   = r_inf;

endmodule
